// File: rtl/uart_rx_framer_pkg.sv
// Shared UART receive definitions: frame width, receiver FSM encoding and bit-timing helpers.
// The timing helpers are also used by the UART transmitter.
package uart_rx_framer_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    function automatic int symbol_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int sample_cycles(input int clk_hz, input int baud);
        return (clk_hz / baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra MSB to tell full from empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: 2-flop synchroniser, start/data/stop FSM and a ready/valid byte output.
// Define UART_RX_FIFO_EN to buffer received bytes in a FIFO_DEPTH-entry FIFO instead of one register.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      serial_in,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_out_valid,
    input  logic                      data_out_ready,
    output logic                      framing_error,
    output logic                      overrun,
    input  logic                      overrun_clear,
    output logic [2:0]                o_dbg_state
);

    localparam int SYMBOL_EDGE_TIME = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME) + 1;
    localparam logic [CNT_W-1:0]     CNT_SAMPLE = CNT_W'(SAMPLE_TIME);
    localparam logic [CNT_W-1:0]     CNT_EDGE   = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(UART_DATA_BITS - 1);

    // Handshake: a byte transfers on any cycle where data_out_valid and data_out_ready are both
    // high; while valid is high and ready low, data_out holds its value.

    logic                      r_sync_1;
    logic                      r_rx_s;
    rx_state_t                 r_state;
    rx_state_t                 w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [BIT_IDX_W-1:0]      r_bit_idx;
    logic [BIT_IDX_W-1:0]      w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_byte_done;
    logic                      w_stop_bad;
    logic                      w_drop;
    logic                      r_framing_error;
    logic                      r_overrun;

    assign o_dbg_state   = r_state;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;

    // Synchroniser resets to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_1 <= 1'b1;
            r_rx_s   <= 1'b1;
        end else begin
            r_sync_1 <= serial_in;
            r_rx_s   <= r_sync_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_done   = 1'b0;
        w_stop_bad    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_SAMPLE) begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_DATA;
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_EDGE) begin
                    w_shift_nxt[r_bit_idx] = r_rx_s;
                    w_cnt_nxt              = '0;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (r_cnt == CNT_EDGE) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_BREAK: begin
                // Holding here until the line recovers keeps a break to one framing error.
                if (r_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_framing_error <= 1'b0;
        end else begin
            r_framing_error <= w_stop_bad;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_pop;
    logic [UART_DATA_BITS-1:0] w_fifo_head;

    assign w_pop          = data_out_ready && !w_fifo_empty;
    assign w_drop         = w_byte_done && w_fifo_full && !w_pop;
    assign data_out_valid = !w_fifo_empty;
    assign data_out       = w_fifo_empty ? '0 : w_fifo_head;

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_byte_done),
        .push_data (r_shift),
        .pop       (w_pop),
        .head_data (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );
`else
    logic [UART_DATA_BITS-1:0] r_data_out;
    logic                      r_data_valid;

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_valid;
    assign w_drop         = w_byte_done && r_data_valid && !data_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (w_byte_done && (!r_data_valid || data_out_ready)) begin
            r_data_out   <= r_shift;
            r_data_valid <= 1'b1;
        end else if (r_data_valid && data_out_ready) begin
            r_data_valid <= 1'b0;
        end
    end
`endif

    // Setting has priority over clearing so a byte lost during a clear is still reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clear) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer at 5 clocks per bit; covers both buffer builds.
module tb_uart_rx_framer;

  localparam int BIT = 5;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;
  logic       overrun_clear;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int exp_ferr = 0;
  bit rand_ready = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    bit         glitch;
    bit         exp_valid;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx_framer #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (10_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .overrun_clear (overrun_clear),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor (opposite edge) ----------------
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (framing_error) n_ferr++;
      if (hold_prev) begin
        check("hold_valid", {31'd0, data_out_valid}, 32'd1);
        check("hold_stable", {24'd0, data_out}, {24'd0, data_prev});
      end
      if (data_out_valid && data_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected got=%0h expected=none", data_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          checks--;
          check("xfer_data", {24'd0, data_out}, {24'd0, e});
        end
      end
    end
    hold_prev = !rst && data_out_valid && !data_out_ready;
    data_prev = data_out;
  end

  // ---------------- drivers (inputs change 1 time unit after the active edge) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) data_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive(input logic b, input int n);
    serial_in = b;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    if (stop_low > 0) drive(1'b0, stop_low);
    drive(1'b1, BIT);
  endtask

  task automatic drain(input string name);
    data_out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    check(name, exp_q.size(), 0);
  endtask

  // n back-to-back frames with ready low: the first CAP fit, any further byte is lost.
  task automatic burst(input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] v;
    data_out_ready = 1'b0;
    tick();
    for (int k = 0; k < n; k++) begin
      v = first + 8'(k) * step;
      if (k < CAP) exp_q.push_back(v);
      send_frame(v, 0);
    end
    drive(1'b1, 10);
    check("burst_valid", {31'd0, data_out_valid}, 32'd1);
    check("burst_head", {24'd0, data_out}, {24'd0, first});
    check("burst_overrun", {31'd0, overrun}, (n > CAP) ? 32'd1 : 32'd0);
    overrun_clear = 1'b1;
    tick();
    overrun_clear = 1'b0;
    tick();
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    drain("burst_drain");
    check("burst_idle_valid", {31'd0, data_out_valid}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] partial;
    logic [7:0] v;

    vecs[0] = '{8'h61, 0,  1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 0,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h33, 20, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h0D, 0,  1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 0,  1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 0,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 5,  1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h01, 0,  1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b0;
    overrun_clear = 1'b0;
    repeat (3) tick();
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_ferr", {31'd0, framing_error}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 4);
    data_out_ready = 1'b1;

    // table-driven single frames
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].glitch) begin
        drive(1'b0, 2);
        drive(1'b1, 10);
        check("glitch_no_valid", {31'd0, data_out_valid}, 32'd0);
      end
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      if (vecs[i].exp_ferr) exp_ferr++;
      send_frame(vecs[i].data, vecs[i].stop_low);
      drive(1'b1, 15);
      check("vec_ferr_count", n_ferr, exp_ferr);
      check("vec_delivered", exp_q.size(), 0);
      check("vec_valid_idle", {31'd0, data_out_valid}, 32'd0);
      check("vec_overrun", {31'd0, overrun}, 32'd0);
    end

    // overrun / buffering corner cases
    burst(2, 8'hCA, 8'h34);
    burst(CAP + 1, 8'h00, 8'h01);

    // reset during data bit 4 of 8'hA5 loses the byte silently
    partial = 8'hA5;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(partial[i], BIT);
    drive(partial[4], 2);
    rst = 1'b1;
    serial_in = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    drive(1'b1, 60);
    check("rstmid_valid", {31'd0, data_out_valid}, 32'd0);
    check("rstmid_ferr", n_ferr, exp_ferr);
    check("rstmid_overrun", {31'd0, overrun}, 32'd0);
    check("rstmid_state", {29'd0, dbg_state}, 32'd0);
    exp_q.push_back(8'h3E);
    send_frame(8'h3E, 0);
    drive(1'b1, 10);
    check("after_rst_rx", exp_q.size(), 0);

    // randomized frames, gaps, bad stop bits and consumer stalls
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        exp_ferr++;
        send_frame(v, $urandom_range(5, 15));
      end else begin
        exp_q.push_back(v);
        send_frame(v, 0);
      end
      drive(1'b1, $urandom_range(0, 6));
    end
    rand_ready = 1'b0;
    drive(1'b1, 10);
    drain("rand_drain");
    check("rand_ferr_count", n_ferr, exp_ferr);
    check("rand_overrun", {31'd0, overrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
